// File: rtl/fechadura_pkg.sv
// Shared types and constants for the lock front-end: digit buffer layout,
// special key codes and the keypad scan FSM states.
package fechadura_pkg;

    localparam int unsigned NUM_DIGITS = 20;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    // digits[0] is the newest digit
    typedef logic [NUM_DIGITS-1:0][3:0] senhaPac_t;

    localparam senhaPac_t SENHA_VAZIA = {NUM_DIGITS{KEY_NONE}};

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } estado_t;

    // True when exactly one of the three active-low columns is pulled low.
    function automatic logic uma_coluna_baixa(input logic [2:0] col);
        return (col == 3'b110) || (col == 3'b101) || (col == 3'b011);
    endfunction

endpackage

// File: rtl/contador_estavel.sv
// Counts consecutive cycles in which 'stable' holds; any break or an explicit
// clear restarts the count. done stays high once LIMIT cycles have been seen.
module contador_estavel
    import fechadura_pkg::*;
#(
    parameter int unsigned LIMIT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stable,
    output logic done
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || clear || !stable) begin
            cnt <= '0;
        end else if (cnt != LIMIT_V) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == LIMIT_V);

endmodule

// File: rtl/teclado_matricial.sv
// 4x3 matrix keypad scanner: row scan, press/release debounce, key encoding
// and a 20-digit shift buffer with per-key valid pulse and idle timeout.
module teclado_matricial
    import fechadura_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    input  logic [2:0] col_matriz,
    output logic [3:0] lin_matriz,
    output senhaPac_t digitos_value,
    output logic      digitos_valid
);

    localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYCLES);

    estado_t        state;
    estado_t        state_next;
    logic           ativo;
    logic [1:0]     row;
    logic [SW-1:0]  scan_cnt;
    logic [2:0]     col_lat;
    logic [TW-1:0]  idle_cnt;
    senhaPac_t      digits;
    logic           valid_q;

    logic           cont_clear;
    logic           cont_stable;
    logic           cont_done;
    logic           tecla_unica;

    function automatic logic [3:0] codificar(input logic [1:0] r, input logic [2:0] col);
        logic [1:0] c;
        c = (col == 3'b110) ? 2'd0 : ((col == 3'b101) ? 2'd1 : 2'd2);
        if (r == 2'd3) begin
            case (c)
                2'd0:    return KEY_STAR;
                2'd1:    return 4'h0;
                default: return KEY_HASH;
            endcase
        end
        return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    endfunction

    assign tecla_unica = ativo && uma_coluna_baixa(col_matriz);

    // One counter serves both phases: same column held while debouncing the
    // press, all columns high while debouncing the release.
    assign cont_clear  = !enable || (state == SCAN) || (state == EMIT);
    assign cont_stable = (state == DEBOUNCE) ? (col_matriz == col_lat)
                                             : (col_matriz == 3'b111);

    contador_estavel #(
        .LIMIT (DEBOUNCE_CYCLES)
    ) u_contador (
        .clk    (clk),
        .rst    (rst),
        .clear  (cont_clear),
        .stable (cont_stable),
        .done   (cont_done)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            SCAN: begin
                if (tecla_unica) state_next = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (col_matriz != col_lat) state_next = SCAN;
                else if (cont_done)        state_next = EMIT;
            end
            EMIT: begin
                state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (cont_done) state_next = SCAN;
            end
            default: state_next = SCAN;
        endcase
        if (!enable) state_next = SCAN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCAN;
            ativo <= 1'b0;
        end else begin
            state <= state_next;
            ativo <= enable;
        end
    end

    // Row rotation only while idle-scanning; the row freezes once a key is seen.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            row      <= 2'd0;
            scan_cnt <= '0;
        end else if (state == SCAN && ativo && !tecla_unica) begin
            if (scan_cnt == SCAN_LAST) begin
                row      <= row + 1'b1;
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end else if (state != SCAN) begin
            scan_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            col_lat <= 3'b111;
        end else if (state == SCAN && tecla_unica) begin
            col_lat <= col_matriz;
        end
    end

    // NOTE: the digit buffer is a plain register bank, not a RAM, so it can and
    // does take a reset value.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            digits   <= SENHA_VAZIA;
            valid_q  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            valid_q <= (state == EMIT);
            if (state == EMIT) begin
                digits   <= {digits[NUM_DIGITS-2:0], codificar(row, col_lat)};
                idle_cnt <= '0;
            end else if (valid_q && (digits[0] == KEY_STAR || digits[0] == KEY_HASH)) begin
                digits   <= SENHA_VAZIA;
                idle_cnt <= '0;
            end else if (digits == SENHA_VAZIA) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TIMEOUT_V) begin
                digits   <= SENHA_VAZIA;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign lin_matriz    = ativo ? ~(4'b0001 << row) : 4'b1111;
    assign digitos_value = digits;
    assign digitos_valid = valid_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Scoreboard bench: a keypad model presses keys, a queue-based digit model
// predicts each pulse, and a monitor compares whenever digitos_valid is seen.
module tb_teclado_matricial;
    import fechadura_pkg::*;

    localparam int unsigned SCAN_C = 2;
    localparam int unsigned DEB_C  = 4;
    localparam int unsigned TMO_C  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] col_matriz;
    logic [3:0] lin_matriz;
    senhaPac_t  digitos_value;
    logic       digitos_valid;

    logic       key_down = 1'b0;
    logic [1:0] key_row  = 2'd0;
    logic [1:0] key_col  = 2'd0;

    typedef struct {
        senhaPac_t value;
        bit        clears;
    } esperado_t;

    esperado_t  sb[$];
    logic [3:0] model_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    bit         clear_due = 1'b0;

    teclado_matricial #(
        .SCAN_CYCLES     (SCAN_C),
        .DEBOUNCE_CYCLES (DEB_C),
        .TIMEOUT_CYCLES  (TMO_C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .col_matriz    (col_matriz),
        .lin_matriz    (lin_matriz),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid)
    );

    always #5 clk = ~clk;

    // Passive switch matrix: a held key shorts its column to its row.
    always_comb begin
        col_matriz = 3'b111;
        if (key_down && lin_matriz[key_row] == 1'b0) col_matriz[key_col] = 1'b0;
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic senhaPac_t model_value();
        senhaPac_t v;
        int n;
        n = model_q.size();
        for (int i = 0; i < NUM_DIGITS; i++) v[i] = (i < n) ? model_q[n-1-i] : KEY_NONE;
        return v;
    endfunction

    function automatic void model_push(input logic [3:0] code);
        esperado_t e;
        model_q.push_back(code);
        if (model_q.size() > NUM_DIGITS) void'(model_q.pop_front());
        e.value  = model_value();
        e.clears = (code == KEY_STAR) || (code == KEY_HASH);
        sb.push_back(e);
        if (e.clears) model_q.delete();
    endfunction

    task automatic select_key(input logic [3:0] code);
        if (code == 4'h0)          begin key_row = 2'd3; key_col = 2'd1; end
        else if (code == KEY_STAR) begin key_row = 2'd3; key_col = 2'd0; end
        else if (code == KEY_HASH) begin key_row = 2'd3; key_col = 2'd2; end
        else begin
            key_row = 2'((code - 4'd1) / 4'd3);
            key_col = 2'((code - 4'd1) % 4'd3);
        end
    endtask

    task automatic press_key(input logic [3:0] code, input int hold);
        int start;
        int n;
        start = pulses;
        n = 0;
        model_push(code);
        select_key(code);
        @(negedge clk);
        key_down = 1'b1;
        while (pulses == start && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (8) @(negedge clk);
        check("one_pulse_per_key", 80'(pulses - start), 80'(1));
    endtask

    task automatic wait_row(input logic [1:0] r);
        int n;
        n = 0;
        while (lin_matriz[r] != 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("row_reached", 80'(lin_matriz[r]), 80'(0));
    endtask

    initial begin : monitor
        esperado_t e;
        forever begin
            @(negedge clk);
            if (clear_due) begin
                check("clear_after_star_hash", digitos_value, SENHA_VAZIA);
                clear_due = 1'b0;
            end
            if (!rst && digitos_valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 80'(digitos_valid), 80'(0));
                end else begin
                    e = sb.pop_front();
                    check("pulse_value", digitos_value, e.value);
                    clear_due = e.clears;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        int start;
        logic [3:0] exp_lin;
        logic [3:0] code;

        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_value", digitos_value, SENHA_VAZIA);
        check("reset_valid", 80'(digitos_valid), 80'(0));
        check("reset_lin", 80'(lin_matriz), 80'(4'b1111));
        rst = 1'b0;

        // Row scan: each row low for SCAN_C cycles, row0 first
        n = 0;
        while (lin_matriz == 4'b1111 && n < 8) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            exp_lin = ~(4'b0001 << (i / 2));
            check("scan_rows", 80'(lin_matriz), 80'(exp_lin));
            @(negedge clk);
        end

        // Single key held long: one pulse only
        press_key(4'h5, 15);

        // Let the timeout empty the buffer
        repeat (70) @(negedge clk);
        check("timeout_empty", digitos_value, SENHA_VAZIA);
        model_q.delete();

        // 1..8 then '*'
        for (int k = 1; k <= 8; k++) press_key(4'(k), 2);
        press_key(KEY_STAR, 2);
        check("after_star_empty", digitos_value, SENHA_VAZIA);

        // Bounce on '7': two low cycles at a time never reach the debounce limit
        start = pulses;
        select_key(4'h7);
        for (int b = 0; b < 5; b++) begin
            wait_row(key_row);
            key_down = 1'b1;
            repeat (2) @(negedge clk);
            key_down = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("bounce_no_pulse", 80'(pulses - start), 80'(0));
        check("bounce_buffer", digitos_value, model_value());

        // 22 keys: overflow drops the oldest two
        start = pulses;
        for (int k = 0; k < 22; k++) press_key(4'(k % 10), 1);
        check("overflow_pulses", 80'(pulses - start), 80'(22));
        check("overflow_buffer", digitos_value, model_value());
        check("overflow_newest", 80'(digitos_value[0]), 80'(4'h1));
        check("overflow_oldest", 80'(digitos_value[NUM_DIGITS-1]), 80'(4'h2));

        // Random keys with random hold times
        for (int k = 0; k < 10; k++) begin
            code = 4'($urandom_range(0, 11));
            press_key(code, int'($urandom_range(0, 6)));
        end
        check("random_buffer", digitos_value, model_value());

        // Timeout after '3'
        press_key(4'h3, 2);
        check("before_timeout", digitos_value, model_value());
        start = pulses;
        n = 0;
        while (digitos_value != SENHA_VAZIA && n < 80) begin
            @(negedge clk);
            n++;
        end
        model_q.delete();
        check("timeout_clears", digitos_value, SENHA_VAZIA);
        check("timeout_no_pulse", 80'(pulses - start), 80'(0));

        // Abort mid-debounce by dropping enable
        press_key(4'h7, 2);
        start = pulses;
        select_key(4'h4);
        wait_row(key_row);
        key_down = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        model_q.delete();
        check("abort_lin", 80'(lin_matriz), 80'(4'b1111));
        check("abort_buffer", digitos_value, SENHA_VAZIA);
        check("abort_valid", 80'(digitos_valid), 80'(0));
        repeat (3) @(negedge clk);
        key_down = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("restart_row0", 80'(lin_matriz), 80'(4'b1110));
        repeat (10) @(negedge clk);
        check("abort_no_pulse", 80'(pulses - start), 80'(0));

        // Service still works after re-enable
        press_key(KEY_HASH, 1);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 80'(sb.size()), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
